// File: rtl/if_fetch_queue.sv
// if_fetch_queue
//   Instruction fetch front end. It issues sequential fetch requests to the
//   icache and tracks the PCs of accepted requests in order. Returned
//   instructions are buffered in a small queue for decode. A redirect flushes
//   the queue and restarts fetch at a new PC. Responses that were already in
//   flight when the redirect arrived are discarded as they come back. A
//   misaligned fetch PC produces a single address-error entry and then halts
//   fetch until the next redirect or reset.
//
// Ports
//   clk            in   clock, rising edge
//   reset          in   synchronous, active-high reset
//   redirect_valid in   flush and restart fetch at redirect_pc
//   redirect_pc    in   [31:0] new fetch address
//   inst_valid     out  fetch request to icache
//   inst_addr      out  [31:0] fetch address
//   inst_addr_ok   in   icache accepted the request this cycle
//   inst_data_ok   in   icache returned a response this cycle (in order)
//   inst_rdata     in   [31:0] returned instruction
//   out_valid      out  queue head is valid
//   out_ready      in   decode accepts the head
//   out_pc         out  [31:0] head PC
//   out_inst       out  [31:0] head instruction
//   out_excp_adef  out  head carries an address-error exception
module if_fetch_queue #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_excp_adef
);

  localparam int QW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int IW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [31:0]   fetch_pc;
  logic          halt;

  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   q_inst [DEPTH];
  logic          q_adef [DEPTH];
  logic [PW-1:0] q_head;
  logic [PW-1:0] q_tail;
  logic [QW-1:0] q_cnt;

  logic [31:0]   inf_pc [MAX_OUTSTANDING];
  logic [IW-1:0] inf_head;
  logic [IW-1:0] inf_tail;
  logic [OW-1:0] inf_cnt;
  logic [OW-1:0] inf_cnt_next;
  logic [OW-1:0] discard_cnt;

  logic [QW:0]   occupancy;
  logic          aligned;
  logic          accept;
  logic          resp;
  logic          push_data;
  logic          push_adef;
  logic          push;
  logic          pop;
  logic [31:0]   push_pc;
  logic [31:0]   push_inst;

  // The in-flight FIFO depth need not be a power of two, so wrap explicitly.
  function automatic logic [IW-1:0] inf_next(input logic [IW-1:0] p);
    return (p == IW'(MAX_OUTSTANDING - 1)) ? '0 : p + IW'(1);
  endfunction

  // Every in-flight request owns a queue slot, so a response can always be
  // pushed. Issue is also blocked during a redirect to avoid fetching a stale
  // address. It is blocked during reset so the reset cycle shows no request.
  assign occupancy  = {1'b0, q_cnt} + (QW+1)'(inf_cnt);
  assign aligned    = (fetch_pc[1:0] == 2'b00);
  assign inst_valid = !reset && !halt && aligned && !redirect_valid &&
                      (inf_cnt < OW'(MAX_OUTSTANDING)) &&
                      (occupancy < (QW+1)'(DEPTH));
  assign inst_addr  = fetch_pc;
  assign accept     = inst_valid && inst_addr_ok;

  // A response is stale if it belongs to a request from before a redirect.
  // That is true while discard_cnt is non-zero, or when the redirect arrives
  // in the same cycle as the response.
  assign resp       = inst_data_ok && (inf_cnt != '0);
  assign push_data  = resp && (discard_cnt == '0) && !redirect_valid;

  // A misaligned PC is reported once, in order. This happens only after all
  // earlier requests have drained, and only if there is room in the queue.
  assign push_adef  = !aligned && !halt && !redirect_valid &&
                      (inf_cnt == '0) && (q_cnt != QW'(DEPTH));

  assign push       = push_data || push_adef;
  assign push_pc    = push_adef ? fetch_pc : inf_pc[inf_head];
  assign push_inst  = push_adef ? 32'h0 : inst_rdata;

  assign out_valid  = (q_cnt != '0);
  assign pop        = out_valid && out_ready;

  // The outputs are forced to zero when the queue is empty, so the
  // unreset storage never shows at the ports.
  assign out_pc        = out_valid ? q_pc[q_head]   : 32'h0;
  assign out_inst      = out_valid ? q_inst[q_head] : 32'h0;
  assign out_excp_adef = out_valid ? q_adef[q_head] : 1'b0;

  assign inf_cnt_next  = inf_cnt + OW'(accept) - OW'(resp);

  // Control state. Responses keep draining the in-flight FIFO even during a
  // redirect, so the discard count is loaded with the post-update count.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      halt        <= 1'b0;
      q_head      <= '0;
      q_tail      <= '0;
      q_cnt       <= '0;
      inf_head    <= '0;
      inf_tail    <= '0;
      inf_cnt     <= '0;
      discard_cnt <= '0;
    end else begin
      inf_cnt <= inf_cnt_next;
      if (accept) inf_tail <= inf_next(inf_tail);
      if (resp)   inf_head <= inf_next(inf_head);
      if (redirect_valid) begin
        fetch_pc    <= redirect_pc;
        halt        <= 1'b0;
        discard_cnt <= inf_cnt_next;
        q_head      <= '0;
        q_tail      <= '0;
        q_cnt       <= '0;
      end else begin
        if (accept)    fetch_pc <= fetch_pc + 32'd4;
        if (push_adef) halt     <= 1'b1;
        if (resp && (discard_cnt != '0)) discard_cnt <= discard_cnt - OW'(1);
        if (push) q_tail <= q_tail + PW'(1);
        if (pop)  q_head <= q_head + PW'(1);
        q_cnt <= q_cnt + QW'(push) - QW'(pop);
      end
    end
  end

  // Storage arrays have no reset. Valid entries are tracked by the counters.
  always_ff @(posedge clk) begin
    if (accept) inf_pc[inf_tail] <= fetch_pc;
    if (push) begin
      q_pc[q_tail]   <= push_pc;
      q_inst[q_tail] <= push_inst;
      q_adef[q_tail] <= push_adef;
    end
  end

endmodule
